// File: rtl/distortion_shaper_if.sv
`default_nettype none
// ============================================================================
// Module      : distortion_shaper_if
// Description : Bus bundle between the effect chain (master) and the
//               distortion shaper (slave).
//               Master drives: cs, my_turn, data_in, gain_key, mode_key.
//               Slave drives : done, data_out, gain_idx, mode.
// Revision    : 1.0 - initial release
// ============================================================================
interface distortion_shaper_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                         cs;
    logic                         my_turn;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         gain_key;
    logic                         mode_key;
    logic                         done;
    logic signed [DATA_WIDTH-1:0] data_out;
    logic [2:0]                   gain_idx;
    logic [1:0]                   mode;

    modport master (
        output cs, my_turn, data_in, gain_key, mode_key,
        input  done, data_out, gain_idx, mode
    );

    modport slave (
        input  cs, my_turn, data_in, gain_key, mode_key,
        output done, data_out, gain_idx, mode
    );
endinterface
`default_nettype wire

// File: rtl/distortion_shaper.sv
`default_nettype none
// ============================================================================
// Module      : distortion_shaper
// Description : Gain + shaping stage (bypass / hard clip / soft clip) with a
//               fixed-latency iterative divide-by-3 for the soft-clip knee.
// Ports       : clk  - system clock (rising edge)
//               rst  - synchronous active-high reset
//               bus  - distortion_shaper_if.slave: request handshake
//                      (cs, my_turn, data_in), control keys (gain_key,
//                      mode_key), result (done, data_out) and status
//                      (gain_idx, mode)
// Revision    : 1.0 - initial release
// ============================================================================
module distortion_shaper #(
    parameter int DATA_WIDTH = 16,
    parameter int GAIN_COUNT = 4,
    parameter int THRESH     = 10922
) (
    input  wire logic          clk,
    input  wire logic          rst,
    distortion_shaper_if.slave bus
);

    // Wide enough that gain, doubling and abs never wrap.
    localparam int c_ACC_W = DATA_WIDTH + GAIN_COUNT + 2;
    localparam int c_CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic signed [c_ACC_W-1:0] c_MAX  = c_ACC_W'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
    localparam logic signed [c_ACC_W-1:0] c_MIN  = -c_ACC_W'(64'sd1 <<< (DATA_WIDTH-1));
    localparam logic signed [c_ACC_W-1:0] c_T    = c_ACC_W'(THRESH);
    localparam logic signed [c_ACC_W-1:0] c_2T   = c_ACC_W'(2 * THRESH);
    localparam logic signed [c_ACC_W-1:0] c_NMAX = c_ACC_W'((64'sd1 <<< DATA_WIDTH) - 64'sd1);

    localparam logic signed [DATA_WIDTH-1:0] c_MAX_D = DATA_WIDTH'(c_MAX);
    localparam logic signed [DATA_WIDTH-1:0] c_MIN_D = DATA_WIDTH'(c_MIN);

    localparam logic [1:0]         c_MODE_BYPASS = 2'd0;
    localparam logic [1:0]         c_MODE_HARD   = 2'd1;
    localparam logic [1:0]         c_MODE_SOFT   = 2'd2;
    localparam logic [2:0]         c_GAIN_LAST   = 3'(GAIN_COUNT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST    = c_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BOOST = 3'd1,
        S_DIV   = 3'd2,
        S_SHAPE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                       state_q, state_d;
    logic signed [DATA_WIDTH-1:0] data_q;
    logic [2:0]                   gain_q;
    logic [1:0]                   mode_lat_q;
    logic signed [c_ACC_W-1:0]    xb_q;
    logic [DATA_WIDTH-1:0]        num_q;
    logic [DATA_WIDTH-1:0]        quo_q;
    logic [1:0]                   rem_q;
    logic [c_CNT_W-1:0]           cnt_q;
    logic signed [DATA_WIDTH-1:0] data_out_q;
    logic [2:0]                   gain_idx_q;
    logic [1:0]                   mode_q;

    logic                         w_accept;
    logic signed [c_ACC_W-1:0]    w_data_ext;
    logic signed [c_ACC_W-1:0]    w_xb;
    logic signed [c_ACC_W-1:0]    w_abs;
    logic signed [c_ACC_W-1:0]    w_diff;
    logic [DATA_WIDTH-1:0]        w_num;
    logic [2:0]                   w_trial;
    logic                         w_qbit;
    logic [1:0]                   w_rem_next;
    logic signed [c_ACC_W-1:0]    w_2xb;
    logic signed [DATA_WIDTH-1:0] w_y;

    assign w_accept = (state_q == S_IDLE) && bus.my_turn && bus.cs;

    // ------------------------------------------------------------------
    // Boost: xb = data << g, divider numerator n = clamp(2T - |xb|)
    // ------------------------------------------------------------------
    assign w_data_ext = {{(c_ACC_W-DATA_WIDTH){data_q[DATA_WIDTH-1]}}, data_q};
    assign w_xb       = w_data_ext <<< gain_q;
    assign w_abs      = w_xb[c_ACC_W-1] ? -w_xb : w_xb;
    assign w_diff     = c_2T - w_abs;

    always_comb begin
        w_num = '0;
        if (w_diff[c_ACC_W-1]) begin
            w_num = '0;
        end else if (w_diff > c_NMAX) begin
            w_num = '1;
        end else begin
            w_num = DATA_WIDTH'(w_diff);
        end
    end

    // ------------------------------------------------------------------
    // Restoring divide by 3: the remainder never exceeds 2, so a 3-bit
    // trial value is enough for each step.
    // ------------------------------------------------------------------
    assign w_trial    = {rem_q, num_q[DATA_WIDTH-1]};
    assign w_qbit     = (w_trial >= 3'd3);
    assign w_rem_next = w_qbit ? 2'(w_trial - 3'd3) : w_trial[1:0];

    // ------------------------------------------------------------------
    // Shaping
    // ------------------------------------------------------------------
    assign w_2xb = xb_q <<< 1;

    always_comb begin
        w_y = data_q;
        case (mode_lat_q)
            c_MODE_HARD: begin
                if (w_2xb > c_MAX) begin
                    w_y = c_MAX_D;
                end else if (w_2xb < c_MIN) begin
                    w_y = c_MIN_D;
                end else begin
                    w_y = DATA_WIDTH'(w_2xb);
                end
            end
            c_MODE_SOFT: begin
                if (xb_q >= c_2T) begin
                    w_y = c_MAX_D;
                end else if (xb_q <= -c_2T) begin
                    w_y = c_MIN_D;
                end else if (xb_q >= c_T) begin
                    w_y = c_MAX_D - quo_q;
                end else if (xb_q <= -c_T) begin
                    w_y = quo_q - c_MAX_D;
                end else begin
                    w_y = DATA_WIDTH'(w_2xb);
                end
            end
            default: w_y = data_q;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept) state_d = S_BOOST;
            S_BOOST: state_d = S_DIV;
            S_DIV:   if (cnt_q == c_CNT_LAST) state_d = S_SHAPE;
            S_SHAPE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            gain_q     <= '0;
            mode_lat_q <= c_MODE_BYPASS;
            xb_q       <= '0;
            num_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            gain_idx_q <= '0;
            mode_q     <= c_MODE_BYPASS;
        end else begin
            // Keys act in every state; the sample in flight uses its
            // own latched copies, so only the next sample sees them.
            if (bus.gain_key) begin
                gain_idx_q <= (gain_idx_q == c_GAIN_LAST) ? 3'd0 : gain_idx_q + 3'd1;
            end
            if (bus.mode_key) begin
                mode_q <= (mode_q == c_MODE_SOFT) ? c_MODE_BYPASS : mode_q + 2'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        data_q     <= bus.data_in;
                        gain_q     <= gain_idx_q;
                        mode_lat_q <= mode_q;
                    end
                end
                S_BOOST: begin
                    xb_q  <= w_xb;
                    num_q <= w_num;
                    quo_q <= '0;
                    rem_q <= '0;
                    cnt_q <= '0;
                end
                S_DIV: begin
                    rem_q <= w_rem_next;
                    quo_q <= {quo_q[DATA_WIDTH-2:0], w_qbit};
                    num_q <= {num_q[DATA_WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + c_CNT_W'(1);
                end
                S_SHAPE: begin
                    data_out_q <= w_y;
                end
                default: ;
            endcase
        end
    end

    assign bus.done     = (state_q == S_DONE);
    assign bus.data_out = data_out_q;
    assign bus.gain_idx = gain_idx_q;
    assign bus.mode     = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_distortion_shaper.sv
`default_nettype none
// ============================================================================
// Module      : tb_distortion_shaper
// Description : Self-checking bench for distortion_shaper with an
//               arithmetic reference model of the shaping rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_distortion_shaper;

    localparam int DW   = 16;
    localparam int GC   = 4;
    localparam int T    = 10922;
    localparam int MAXV = 32767;
    localparam int MINV = -32768;
    localparam int LAT  = DW + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    distortion_shaper_if #(.DATA_WIDTH(DW)) bus ();

    distortion_shaper #(
        .DATA_WIDTH(DW),
        .GAIN_COUNT(GC),
        .THRESH    (T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int m_gain = 0;
    int m_mode = 0;

    function automatic int ref_out(input int d, input int g, input int md);
        longint xb, a, v, q;
        xb = longint'(d) * (longint'(1) << g);
        a  = (xb < 0) ? -xb : xb;
        if (md == 0) return d;
        if (md == 1) begin
            v = 2 * xb;
            if (v > MAXV) v = MAXV;
            if (v < MINV) v = MINV;
            return int'(v);
        end
        if (a < T)        return int'(2 * xb);
        if (xb >= 2 * T)  return MAXV;
        if (xb <= -2 * T) return MINV;
        q = (2 * T - a) / 3;
        return (xb > 0) ? int'(MAXV - q) : int'(-MAXV + q);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input bit gk, input bit mk);
        bus.gain_key = gk;
        bus.mode_key = mk;
        step();
        bus.gain_key = 1'b0;
        bus.mode_key = 1'b0;
        if (gk) m_gain = (m_gain + 1) % GC;
        if (mk) m_mode = (m_mode + 1) % 3;
    endtask

    // Issue one request and wait (bounded) for its done pulse.
    task automatic run_sample(input int d, output int lat, output int y, output logic dn_after);
        bus.cs      = 1'b1;
        bus.my_turn = 1'b1;
        bus.data_in = d[DW-1:0];
        step();
        bus.cs      = 1'b0;
        bus.my_turn = 1'b0;
        bus.data_in = DW'($urandom);
        lat = -1;
        y   = 0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            step();
            if (bus.done === 1'b1) begin
                lat = k;
                y   = int'($signed(bus.data_out));
            end
        end
        step();
        dn_after = bus.done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        m_gain = 0;
        m_mode = 0;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.data_out !== 16'sd0) begin errors++; $display("FAIL reset_data got=%0d want=0", $signed(bus.data_out)); end
        checks++; if (bus.gain_idx !== 3'd0) begin errors++; $display("FAIL reset_gain got=%0d want=0", bus.gain_idx); end
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL reset_mode got=%0d want=0", bus.mode); end
    endtask

    task automatic test_bypass();
        int lat, y;
        logic dn;
        run_sample(-1234, lat, y, dn);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL bypass_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (y !== -1234) begin errors++; $display("FAIL bypass_data got=%0d want=-1234", y); end
        checks++; if (dn !== 1'b0) begin errors++; $display("FAIL bypass_done_width got=%b want=0", dn); end
        checks++; if (bus.gain_idx !== 3'd0) begin errors++; $display("FAIL bypass_gain got=%0d want=0", bus.gain_idx); end
        checks++; if (bus.mode !== 2'd0) begin errors++; $display("FAIL bypass_mode got=%0d want=0", bus.mode); end
    endtask

    task automatic test_soft();
        int din[5]  = '{1000, 15000, -15000, 22000, -22000};
        int dexp[5] = '{2000, 30486, -30486, 32767, -32768};
        int lat, y;
        logic dn;
        for (int i = 0; i < 3 && m_mode != 2; i++) press(1'b0, 1'b1);
        checks++; if (bus.mode !== 2'd2) begin errors++; $display("FAIL soft_mode got=%0d want=2", bus.mode); end
        for (int i = 0; i < 5; i++) begin
            run_sample(din[i], lat, y, dn);
            checks++; if (y !== dexp[i] || lat !== LAT) begin
                errors++; $display("FAIL soft_%0d got=%0d lat=%0d want=%0d lat=%0d", din[i], y, lat, dexp[i], LAT);
            end
        end
    endtask

    task automatic test_hard();
        int din[3]  = '{20000, -20000, 5000};
        int dexp[3] = '{32767, -32768, 10000};
        int lat, y;
        logic dn;
        for (int i = 0; i < 3 && m_mode != 1; i++) press(1'b0, 1'b1);
        checks++; if (bus.mode !== 2'd1) begin errors++; $display("FAIL hard_mode got=%0d want=1", bus.mode); end
        for (int i = 0; i < 3; i++) begin
            run_sample(din[i], lat, y, dn);
            checks++; if (y !== dexp[i] || lat !== LAT) begin
                errors++; $display("FAIL hard_%0d got=%0d lat=%0d want=%0d lat=%0d", din[i], y, lat, dexp[i], LAT);
            end
        end
    endtask

    task automatic test_gain();
        int lat, y;
        logic dn;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        checks++; if (bus.gain_idx !== 3'd2) begin errors++; $display("FAIL gain_idx2 got=%0d want=2", bus.gain_idx); end
        for (int i = 0; i < 3 && m_mode != 2; i++) press(1'b0, 1'b1);
        run_sample(3000, lat, y, dn);
        checks++; if (y !== 29486) begin errors++; $display("FAIL gain_soft got=%0d want=29486", y); end
        // Both keys together advance both.
        press(1'b1, 1'b1);
        press(1'b1, 1'b0);
        checks++; if (bus.gain_idx !== 3'd0) begin errors++; $display("FAIL gain_wrap got=%0d want=0", bus.gain_idx); end
        checks++; if (bus.mode !== 2'(m_mode)) begin errors++; $display("FAIL both_keys_mode got=%0d want=%0d", bus.mode, m_mode); end
    endtask

    task automatic test_midsample();
        int lat, y, extra, old_mode, y2;
        logic dn;
        old_mode = m_mode;
        bus.cs = 1'b1; bus.my_turn = 1'b1; bus.data_in = 16'sd15000;
        step();
        bus.cs = 1'b0; bus.my_turn = 1'b0;
        lat = -1; y = 0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            if (k == 5) begin
                bus.mode_key = 1'b1; bus.cs = 1'b1; bus.my_turn = 1'b1; bus.data_in = 16'sd1000;
            end
            step();
            if (k == 5) begin
                bus.mode_key = 1'b0; bus.cs = 1'b0; bus.my_turn = 1'b0;
                m_mode = (m_mode + 1) % 3;
            end
            if (bus.done === 1'b1) begin lat = k; y = int'($signed(bus.data_out)); end
        end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL mid_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (y !== ref_out(15000, m_gain, old_mode)) begin
            errors++; $display("FAIL mid_latched_mode got=%0d want=%0d", y, ref_out(15000, m_gain, old_mode));
        end
        extra = 0;
        for (int k = 0; k < 30; k++) begin step(); if (bus.done === 1'b1) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL mid_no_queue got=%0d pulses want=0", extra); end
        run_sample(15000, lat, y2, dn);
        checks++; if (y2 !== ref_out(15000, m_gain, m_mode)) begin
            errors++; $display("FAIL mid_next_mode got=%0d want=%0d", y2, ref_out(15000, m_gain, m_mode));
        end
    endtask

    task automatic test_rst_mid();
        int lat, y, pulses;
        logic dn;
        press(1'b1, 1'b0);
        bus.cs = 1'b1; bus.my_turn = 1'b1; bus.data_in = 16'sd7777;
        step();
        bus.cs = 1'b0; bus.my_turn = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) begin rst = 1'b1; bus.gain_key = 1'b1; bus.mode_key = 1'b1; end
            step();
            if (bus.done === 1'b1) pulses++;
        end
        rst = 1'b0; bus.gain_key = 1'b0; bus.mode_key = 1'b0;
        m_gain = 0; m_mode = 0;
        for (int k = 0; k < 30; k++) begin step(); if (bus.done === 1'b1) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_no_done got=%0d pulses want=0", pulses); end
        checks++; if (bus.data_out !== 16'sd0) begin errors++; $display("FAIL rst_data got=%0d want=0", $signed(bus.data_out)); end
        checks++; if (bus.gain_idx !== 3'd0 || bus.mode !== 2'd0) begin
            errors++; $display("FAIL rst_keys got=%0d/%0d want=0/0", bus.gain_idx, bus.mode);
        end
        run_sample(-1234, lat, y, dn);
        checks++; if (lat !== LAT || y !== -1234) begin
            errors++; $display("FAIL rst_recover got=%0d lat=%0d want=-1234 lat=%0d", y, lat, LAT);
        end
    endtask

    task automatic test_random();
        int lat, y, d, want;
        logic dn;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            d = int'($urandom_range(0, 65535)) - 32768;
            want = ref_out(d, m_gain, m_mode);
            run_sample(d, lat, y, dn);
            checks++; if (y !== want || lat !== LAT || dn !== 1'b0) begin
                errors++; $display("FAIL rand_%0d d=%0d g=%0d m=%0d got=%0d lat=%0d want=%0d", i, d, m_gain, m_mode, y, lat, want);
            end
            checks++; if (bus.gain_idx !== 3'(m_gain) || bus.mode !== 2'(m_mode)) begin
                errors++; $display("FAIL rand_state_%0d got=%0d/%0d want=%0d/%0d", i, bus.gain_idx, bus.mode, m_gain, m_mode);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.cs       = 1'b0;
        bus.my_turn  = 1'b0;
        bus.data_in  = '0;
        bus.gain_key = 1'b0;
        bus.mode_key = 1'b0;
        test_reset();
        test_bypass();
        test_soft();
        test_hard();
        test_gain();
        test_midsample();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
